// File: rtl/kamus_store_buffer.sv
// rtl/kamus_store_buffer.sv - store buffer between kamus_core and L1D: lane formatting, FIFO drain, load check
// Optional: KAMUS_STORE_FWD_EN enables store-to-load forwarding; otherwise any word match stalls.
module kamus_store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             st_valid_i,
    input  logic [1:0]       st_size_i,
    input  logic [31:0]      st_addr_i,
    input  logic [31:0]      st_data_i,
    output logic             st_ready_o,
    output logic             st_misalign_o,
    input  logic             ld_valid_i,
    input  logic [31:0]      ld_addr_i,
    input  logic [3:0]       ld_be_i,
    output logic             ld_fwd_hit_o,
    output logic [31:0]      ld_fwd_data_o,
    output logic             ld_conflict_o,
    output logic             mem_req_o,
    input  logic             mem_gnt_i,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic [3:0]       mem_be_o,
    output logic [CNT_W-1:0] count_o,
    output logic             empty_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      ent_addr [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             misalign_q;

    logic        aligned;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_data;
    logic        push, pop;

    always_comb begin
        aligned  = 1'b0;
        fmt_be   = 4'b0000;
        fmt_data = 32'h0;
        case (st_size_i)
            2'b00: begin
                aligned  = 1'b1;
                fmt_be   = 4'b0001 << st_addr_i[1:0];
                fmt_data = {4{st_data_i[7:0]}};
            end
            2'b01: begin
                aligned  = !st_addr_i[0];
                fmt_be   = st_addr_i[1] ? 4'b1100 : 4'b0011;
                fmt_data = {2{st_data_i[15:0]}};
            end
            2'b10: begin
                aligned  = (st_addr_i[1:0] == 2'b00);
                fmt_be   = 4'b1111;
                fmt_data = st_data_i;
            end
            default: aligned = 1'b0;
        endcase
    end

    assign empty_o       = (count == '0);
    assign count_o       = count;
    assign st_ready_o    = (count < CNT_W'(DEPTH));
    assign st_misalign_o = misalign_q;
    assign mem_req_o     = !empty_o;
    assign push          = st_valid_i && st_ready_o && aligned;
    assign pop           = mem_req_o && mem_gnt_i;

    // Head fields are zeroed when empty so stale entries never leak onto the bus.
    assign mem_addr_o  = empty_o ? 32'h0 : {ent_addr[rd_ptr], 2'b00};
    assign mem_wdata_o = empty_o ? 32'h0 : ent_data[rd_ptr];
    assign mem_be_o    = empty_o ? 4'h0  : ent_be[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ent_valid  <= '0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= st_valid_i && !aligned;
            // Push and pop never target the same slot: that needs count 0 or DEPTH.
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + 1'b1;
            end
            if (push) begin
                ent_addr[wr_ptr]  <= st_addr_i[31:2];
                ent_be[wr_ptr]    <= fmt_be;
                ent_data[wr_ptr]  <= fmt_data;
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    logic             match;
    logic [3:0]       match_be;
    logic [31:0]      match_data;
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        match      = 1'b0;
        match_be   = 4'b0000;
        match_data = 32'h0;
        idx        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (ent_valid[idx] && ent_addr[idx] == ld_addr_i[31:2]) begin
                match      = 1'b1;
                match_be   = ent_be[idx];
                match_data = ent_data[idx];
            end
        end
    end

`ifdef KAMUS_STORE_FWD_EN
    logic unused_bits;
    assign unused_bits = ^ld_addr_i[1:0];

    always_comb begin
        ld_fwd_hit_o  = 1'b0;
        ld_fwd_data_o = 32'h0;
        ld_conflict_o = 1'b0;
        if (ld_valid_i && match) begin
            if ((match_be & ld_be_i) == ld_be_i) begin
                ld_fwd_hit_o  = 1'b1;
                ld_fwd_data_o = match_data;
            end else begin
                ld_conflict_o = 1'b1;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{ld_addr_i[1:0], ld_be_i, match_be, match_data};

    assign ld_fwd_hit_o  = 1'b0;
    assign ld_fwd_data_o = 32'h0;
    assign ld_conflict_o = ld_valid_i && match;
`endif

endmodule

// File: doc/kamus_store_buffer.md
Name: kamus_store_buffer

Overview:
- Store buffer directly downstream of the kamus_core L1D data port.
- Accepts byte, half and word stores from the core's memory stage and converts them to word-aligned, byte-enabled writes.
- Queues the writes in a FIFO and drains them to the L1D memory over a req/gnt handshake.
- Checks loads against pending stores so the core never reads stale data.

Parameters:
- DEPTH, 4, number of store entries; power of two, >= 2
- CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-high
- st_valid_i  in  1  store request from core
- st_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- st_addr_i  in  32  store byte address
- st_data_i  in  32  store data, LSB-justified
- st_ready_o  out  1  buffer can accept a store this cycle
- st_misalign_o  out  1  one-cycle error pulse for a rejected store
- ld_valid_i  in  1  load lookup request
- ld_addr_i  in  32  load byte address
- ld_be_i  in  4  byte lanes the load needs
- ld_fwd_hit_o  out  1  load fully satisfied from buffer
- ld_fwd_data_o  out  32  forwarded word, lane-aligned
- ld_conflict_o  out  1  overlap the buffer cannot serve; core stalls
- mem_req_o  out  1  write request to L1D
- mem_gnt_i  in  1  L1D accepts the write
- mem_addr_o  out  32  word address, bits [1:0] = 00
- mem_wdata_o  out  32  lane-aligned write data
- mem_be_o  out  4  byte enables
- count_o  out  CNT_W  current occupancy
- empty_o  out  1  count_o == 0

Behaviour:
- Reset (sync, rst_i=1) values:
  - count, read pointer, write pointer all 0; entries invalid.
  - mem_req_o=0, st_misalign_o=0, ld_fwd_hit_o=0, ld_conflict_o=0.
  - ld_fwd_data_o=0, mem_addr_o=0, mem_wdata_o=0, mem_be_o=0.
  - empty_o=1, st_ready_o=1.
- Reset asserted mid-drain discards every pending entry; no further mem_req_o.
- Lane formatting:
  - Byte: be = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - Half: be = 0011 if addr[1]=0, else 1100; wdata = {2{data[15:0]}}.
  - Word: be = 1111; wdata = data.
- Misalignment:
  - Rejected cases: half with addr[0]=1; word with addr[1:0]!=0; size 11.
  - A rejected store is not enqueued.
  - st_misalign_o is registered: high the cycle after the rejected valid cycle, for one cycle.
- Enqueue:
  - A store is accepted when st_valid_i && st_ready_o && aligned.
  - Entry written at the clock edge: {addr[31:2], be, wdata}.
  - st_ready_o = (count < DEPTH). Combinational, no full-bypass.
- Drain:
  - mem_req_o = !empty; head entry presented on mem_addr_o/mem_wdata_o/mem_be_o.
  - Pop when mem_req_o && mem_gnt_i.
  - mem_req_o and the head fields stay stable until granted.
- Latency: a store accepted into an empty buffer raises mem_req_o the next cycle.
- Occupancy:
  - Push and pop in the same cycle leave count unchanged, including at full: full with pop still reports st_ready_o=0 that cycle.
  - Pointers wrap modulo DEPTH.
- Ordering: drains strictly in FIFO order.
- Load check (combinational; uses only the current registered entries):
  - A store accepted in the same cycle is not visible.
  - The head being popped this cycle is still visible.
  - Youngest entry whose word address equals ld_addr_i[31:2]:
    - No match: hit=0, conflict=0.
    - Match and (entry.be & ld_be_i) == ld_be_i: hit=1, data = entry wdata.
    - Match but coverage incomplete: conflict=1, hit=0.
  - ld_valid_i=0 forces hit=0 and conflict=0.
  - Partial overlap is never merged across entries.

Optional Feature:
- Macro: KAMUS_STORE_FWD_EN.
- Defined: forwarding logic exactly as described in Behaviour.
- Undefined:
  - ld_fwd_hit_o tied 0; ld_fwd_data_o tied 0.
  - ld_conflict_o = ld_valid_i && any valid entry matches the word address, regardless of byte lanes.
  - The core stalls until that store drains.

Test Plan:
- Reset state: after reset -> empty_o=1, count_o=0, mem_req_o=0, st_ready_o=1.
- Store formatting: SB addr 0x00000003 data 0x000000AB, mem_gnt_i=1 -> next cycle mem_req_o=1, mem_addr_o=0x00000000, mem_be_o=1000, mem_wdata_o=0xABABABAB; empty_o=1 the following cycle.
- Backpressure: mem_gnt_i=0, push DEPTH=4 words to 0x10, 0x14, 0x18, 0x1C -> count_o=4, st_ready_o=0; a 5th store is not accepted. Then mem_gnt_i=1 -> drains in order 0x10..0x1C, one per cycle.
- Misalignment: SW addr 0x00000002 -> not enqueued, st_misalign_o high exactly one cycle, count_o unchanged. SH addr 0x00000001 -> same result.
- Forwarding, youngest wins: with gnt=0, SW 0x20 data 0x11111111, then SW 0x20 data 0x22222222. Load 0x20 be=1111 -> hit=1, data 0x22222222.
- Forwarding conflict: with only SB 0x24 buffered, load 0x24 be=1111 -> conflict=1, hit=0. With macro undefined, the 0x20 load case also gives conflict=1, hit=0.
